// File: rtl/axil_adder_pkg.sv
// Shared definitions for the AXI4-Lite adder slave: register offsets, response codes,
// control FSM states and the byte-strobe merge helper.
package axil_adder_pkg;

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_IER   = 8'h04;
  localparam logic [7:0] ADDR_A     = 8'h10;
  localparam logic [7:0] ADDR_B     = 8'h18;
  localparam logic [7:0] ADDR_C     = 8'h20;
  localparam logic [7:0] ADDR_CARRY = 8'h24;
  localparam logic [7:0] ADDR_COUNT = 8'h28;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_adder_pipe.sv
// LAT-stage registered adder producing a 33-bit {carry, sum}, with a matching valid
// shift register so the result pops out exactly LAT cycles after in_valid.
module axil_adder_pipe #(
  parameter int unsigned LAT = 2,
  parameter int unsigned DW  = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in_valid,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          out_valid,
  output logic [DW:0]   sum
);

  logic [LAT-1:0] r_vld;
  logic [DW:0]    r_sum [LAT];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_sum[i] <= '0;
    end else begin
      r_vld[0] <= in_valid;
      r_sum[0] <= {1'b0, a} + {1'b0, b};
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_sum[i] <= r_sum[i-1];
      end
    end
  end

  assign out_valid = r_vld[LAT-1];
  assign sum       = r_sum[LAT-1];

endmodule

// File: rtl/axil_adder_slave.sv
// AXI4-Lite slave exposing an ap_ctrl-style adder: operands A/B, result C/CARRY,
// a completion counter, a clear-on-read done flag and a level interrupt.
module axil_adder_slave
  import axil_adder_pkg::*;
#(
  parameter int unsigned AW  = 6,
  parameter int unsigned DW  = 32,
  parameter int unsigned LAT = 2
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [AW-1:0]   s_axi_awaddr,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  input  logic [DW-1:0]   s_axi_wdata,
  input  logic [DW/8-1:0] s_axi_wstrb,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  output logic [1:0]      s_axi_bresp,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  input  logic [AW-1:0]   s_axi_araddr,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  output logic [DW-1:0]   s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            interrupt
);

  logic            r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [AW-1:0]   r_awaddr;
  logic [DW-1:0]   r_wdata, r_rdata, r_a, r_b, r_c, r_count;
  logic [DW/8-1:0] r_wstrb;
  logic [1:0]      r_bresp, r_rresp;
  logic            r_carry, r_ier, r_done;
  state_t          r_state, w_state_next;

  logic            w_aw_hs, w_w_hs, w_wr_do, w_ar_hs, w_rd_ctrl;
  logic [7:0]      w_waddr, w_araddr;
  logic [DW-1:0]   w_wdata, w_rd_data;
  logic [DW/8-1:0] w_wstrb;
  logic [1:0]      w_wr_resp, w_rd_resp;
  logic            w_wr_a, w_wr_b, w_wr_ier, w_start, w_capture;
  logic            w_pipe_valid;
  logic [DW:0]     w_pipe_sum;

  // A channel arriving in the same cycle as its partner is used directly, so the
  // response comes one cycle after the later handshake.
  assign w_aw_hs = s_axi_awvalid & ~r_aw_held;
  assign w_w_hs  = s_axi_wvalid & ~r_w_held;
  assign w_wr_do = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;
  assign w_waddr = 8'(r_aw_held ? r_awaddr : s_axi_awaddr);
  assign w_wdata = r_w_held ? r_wdata : s_axi_wdata;
  assign w_wstrb = r_w_held ? r_wstrb : s_axi_wstrb;

  always_comb begin
    w_wr_a    = 1'b0;
    w_wr_b    = 1'b0;
    w_wr_ier  = 1'b0;
    w_start   = 1'b0;
    w_wr_resp = RESP_OKAY;
    if (w_wr_do) begin
      case (w_waddr)
        ADDR_CTRL:                          w_start  = w_wstrb[0] & w_wdata[0] & (r_state == IDLE);
        ADDR_IER:                           w_wr_ier = 1'b1;
        ADDR_A:                             w_wr_a   = 1'b1;
        ADDR_B:                             w_wr_b   = 1'b1;
        ADDR_C, ADDR_CARRY, ADDR_COUNT:     w_wr_resp = RESP_OKAY;
        default:                            w_wr_resp = RESP_SLVERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_aw_held <= 1'b0;
      r_awaddr  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if (w_wr_do) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_resp;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= s_axi_awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= s_axi_wdata;
          r_wstrb  <= s_axi_wstrb;
        end
        if (s_axi_bready) r_bvalid <= 1'b0;
      end
    end
  end

  axil_adder_pipe #(
    .LAT (LAT),
    .DW  (DW)
  ) u_pipe (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (w_start),
    .a         (r_a),
    .b         (r_b),
    .out_valid (w_pipe_valid),
    .sum       (w_pipe_sum)
  );

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_state_next = BUSY;
      BUSY: begin
        if (w_pipe_valid) begin
          w_state_next = DONE;
          w_capture    = 1'b1;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_ar_hs   = s_axi_arvalid & ~r_rvalid;
  assign w_araddr  = 8'(s_axi_araddr);
  assign w_rd_ctrl = w_ar_hs & (w_araddr == ADDR_CTRL);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_ier   <= 1'b0;
      r_c     <= '0;
      r_carry <= 1'b0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_wr_a) r_a <= apply_wstrb(r_a, w_wdata, w_wstrb);
      if (w_wr_b) r_b <= apply_wstrb(r_b, w_wdata, w_wstrb);
      if (w_wr_ier && w_wstrb[0]) r_ier <= w_wdata[0];
      if (w_capture) begin
        r_c     <= w_pipe_sum[DW-1:0];
        r_carry <= w_pipe_sum[DW];
        r_count <= r_count + DW'(1);
      end
      // A done-set wins over a coincident clear-on-read.
      if (w_capture) r_done <= 1'b1;
      else if (w_rd_ctrl) r_done <= 1'b0;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (w_araddr)
      ADDR_CTRL:  w_rd_data[2:0] = {r_state == IDLE, r_done, r_state == BUSY};
      ADDR_IER:   w_rd_data[0]   = r_ier;
      ADDR_A:     w_rd_data      = r_a;
      ADDR_B:     w_rd_data      = r_b;
      ADDR_C:     w_rd_data      = r_c;
      ADDR_CARRY: w_rd_data[0]   = r_carry;
      ADDR_COUNT: w_rd_data      = r_count;
      default:    w_rd_resp      = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (s_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  assign s_axi_awready = ~r_aw_held;
  assign s_axi_wready  = ~r_w_held;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = ~r_rvalid;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign interrupt     = r_done & r_ier;

endmodule

// File: tb/tb_axil_adder_slave.sv
// Directed self-checking bench for axil_adder_slave: register access, arithmetic,
// done/interrupt timing, channel skew, busy-time drops and asynchronous reset.
module tb_axil_adder_slave;

  localparam int LAT = 4;
  localparam logic [5:0] A_CTRL = 6'h00, A_IER = 6'h04, A_A = 6'h10, A_B = 6'h18;
  localparam logic [5:0] A_C = 6'h20, A_CARRY = 6'h24, A_COUNT = 6'h28, A_BAD = 6'h3C;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  localparam logic [41:0] RST_VEC = {5'b11100, 2'b00, 2'b00, 32'h0, 1'b0};

  logic clk = 1'b0, nreset = 1'b0;
  logic awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic arvalid = 1'b0, arready, rvalid, rready = 1'b0, irq;
  logic [5:0] awaddr = '0, araddr = '0;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;

  int total = 0, bad = 0, cyc = 0, last_bcyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axil_adder_slave #(.AW(6), .DW(32), .LAT(LAT)) dut (
    .clk(clk), .nreset(nreset),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .interrupt(irq)
  );

  // Bus tasks start and end #1 after a rising edge.
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_ok = 0, w_ok = 0;
    int n = 0;
    awvalid = 1; awaddr = addr; wvalid = 1; wdata = data; wstrb = strb; bready = 1;
    while (!(aw_ok && w_ok) && n < 20) begin
      @(negedge clk);
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      @(posedge clk); #1;
      if (aw_ok) awvalid = 0;
      if (w_ok) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 20);
    last_bcyc = cyc;
    resp = bresp;
    if (!bvalid) begin total++; bad++; $display("FAIL write_timeout addr=%h got bvalid=0 want 1", addr); end
    @(posedge clk); #1;
    bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    arvalid = 1; araddr = addr; rready = 1;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    data = rdata; resp = rresp;
    if (!rvalid) begin total++; bad++; $display("FAIL read_timeout addr=%h got rvalid=0 want 1", addr); end
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic test_reset();
    logic [41:0] obs; logic [31:0] rd; logic [1:0] rr;
    @(negedge clk);
    obs = {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, irq};
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs, RST_VEC); end
    @(posedge clk); #1;
    axi_read(A_CTRL, rd, rr);
    total++; if ({rr, rd} !== {OKAY, 32'h4}) begin bad++; $display("FAIL reset_ctrl got=%h want=%h", {rr, rd}, {OKAY, 32'h4}); end
    axi_read(A_COUNT, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_count got=%h want=0", rd); end
  endtask

  task automatic test_basic_add();
    logic [31:0] rd; logic [1:0] rr;
    axi_write(A_A, 32'h5, 4'hF, rr);
    axi_write(A_B, 32'h7, 4'hF, rr);
    axi_write(A_CTRL, 32'h1, 4'h1, rr);
    total++; if (rr !== OKAY) begin bad++; $display("FAIL basic_start_resp got=%h want=%h", rr, OKAY); end
    repeat (10) @(posedge clk); #1;
    axi_read(A_C, rd, rr);
    total++; if (rd !== 32'hC) begin bad++; $display("FAIL basic_c got=%h want=c", rd); end
    axi_read(A_CARRY, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL basic_carry got=%h want=0", rd); end
    axi_read(A_COUNT, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL basic_count got=%h want=1", rd); end
    axi_read(A_CTRL, rd, rr);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL basic_ctrl_first got=%h want=6", rd); end
    axi_read(A_CTRL, rd, rr);
    total++; if (rd !== 32'h4) begin bad++; $display("FAIL basic_ctrl_second got=%h want=4", rd); end
  endtask

  task automatic test_carry();
    logic [31:0] rd; logic [1:0] rr;
    axi_write(A_A, 32'hFFFF_FFFF, 4'hF, rr);
    axi_write(A_B, 32'h0000_0002, 4'hF, rr);
    axi_write(A_CTRL, 32'h1, 4'h1, rr);
    repeat (10) @(posedge clk); #1;
    axi_read(A_C, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL carry_c got=%h want=1", rd); end
    axi_read(A_CARRY, rd, rr);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL carry_bit got=%h want=1", rd); end
    axi_read(A_COUNT, rd, rr);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL carry_count got=%h want=2", rd); end
    axi_read(A_CTRL, rd, rr);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL carry_ctrl got=%h want=6", rd); end
  endtask

  task automatic test_wstrb();
    logic [31:0] rd; logic [1:0] rr;
    axi_write(A_A, 32'hAABB_CCDD, 4'b0010, rr);
    axi_read(A_A, rd, rr);
    total++; if (rd !== 32'hFFFF_CCFF) begin bad++; $display("FAIL strb_a got=%h want=ffffccff", rd); end
    axi_write(A_IER, 32'h1, 4'b0000, rr);
    axi_read(A_IER, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL strb_ier got=%h want=0", rd); end
    axi_write(A_CTRL, 32'h1, 4'b0010, rr);
    repeat (10) @(posedge clk); #1;
    axi_read(A_COUNT, rd, rr);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL strb_ctrl_count got=%h want=2", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic [1:0] rr;
    int n = 0, tb_cyc;
    axi_write(A_IER, 32'h1, 4'hF, rr);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle got=%b want=0", irq); end
    @(posedge clk); #1;
    axi_write(A_CTRL, 32'h1, 4'h1, rr);
    tb_cyc = last_bcyc;
    do begin @(negedge clk); n++; end while (irq !== 1'b1 && n < 30);
    total++;
    if (irq !== 1'b1 || cyc - tb_cyc != LAT) begin
      bad++; $display("FAIL irq_latency got=%0d irq=%b want=%0d", cyc - tb_cyc, irq, LAT);
    end
    @(posedge clk); #1;
    axi_read(A_C, rd, rr);
    total++; if (rd !== 32'hFFFF_CD01) begin bad++; $display("FAIL irq_c got=%h want=ffffcd01", rd); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b want=1", irq); end
    @(posedge clk); #1;
    axi_read(A_CTRL, rd, rr);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL irq_ctrl got=%h want=6", rd); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq); end
    @(posedge clk); #1;
    axi_write(A_IER, 32'h0, 4'hF, rr);
  endtask

  task automatic test_skew(input bit aw_first, input logic [31:0] data);
    logic [31:0] rd; logic [1:0] rr;
    bit hold_ok = 1;
    bready = 0; awaddr = A_A; wdata = data; wstrb = 4'hF;
    if (aw_first) awvalid = 1; else wvalid = 1;
    @(posedge clk); #1;
    if (aw_first) awvalid = 0; else wvalid = 0;
    @(negedge clk);
    total++;
    if ({awready, wready, bvalid} !== {~aw_first, aw_first, 1'b0}) begin
      bad++; $display("FAIL skew_held aw_first=%b got=%b want=%b", aw_first,
                      {awready, wready, bvalid}, {~aw_first, aw_first, 1'b0});
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (aw_first) wvalid = 1; else awvalid = 1;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    repeat (4) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || bresp !== OKAY) hold_ok = 0;
    end
    total++; if (!hold_ok) begin bad++; $display("FAIL skew_bhold aw_first=%b got unstable want bvalid=1 bresp=0", aw_first); end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    total++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      bad++; $display("FAIL skew_release aw_first=%b got=%b want=011", aw_first, {bvalid, awready, wready});
    end
    @(posedge clk); #1;
    axi_read(A_A, rd, rr);
    total++; if (rd !== data) begin bad++; $display("FAIL skew_data aw_first=%b got=%h want=%h", aw_first, rd, data); end
  endtask

  task automatic test_busy_drop();
    logic [31:0] rd; logic [1:0] rr, rr_a, rr_s;
    axi_write(A_CTRL, 32'h1, 4'h1, rr);
    axi_write(A_A, 32'h100, 4'hF, rr_a);
    axi_write(A_CTRL, 32'h1, 4'h1, rr_s);
    total++; if ({rr_a, rr_s} !== 4'b0) begin bad++; $display("FAIL busy_resp got=%b want=0000", {rr_a, rr_s}); end
    repeat (16) @(posedge clk); #1;
    axi_read(A_C, rd, rr);
    total++; if (rd !== 32'h24) begin bad++; $display("FAIL busy_c got=%h want=24", rd); end
    axi_read(A_COUNT, rd, rr);
    total++; if (rd !== 32'h4) begin bad++; $display("FAIL busy_count got=%h want=4", rd); end
    axi_read(A_A, rd, rr);
    total++; if (rd !== 32'h100) begin bad++; $display("FAIL busy_a got=%h want=100", rd); end
    axi_read(A_CTRL, rd, rr);
    total++; if (rd !== 32'h6) begin bad++; $display("FAIL busy_ctrl got=%h want=6", rd); end
    axi_read(A_BAD, rd, rr);
    total++; if ({rr, rd} !== {SLVERR, 32'h0}) begin bad++; $display("FAIL bad_read got=%h want=%h", {rr, rd}, {SLVERR, 32'h0}); end
    axi_write(A_BAD, 32'h1234, 4'hF, rr);
    total++; if (rr !== SLVERR) begin bad++; $display("FAIL bad_write got=%h want=%h", rr, SLVERR); end
    axi_write(A_C, 32'hDEAD, 4'hF, rr);
    total++; if (rr !== OKAY) begin bad++; $display("FAIL ro_write_resp got=%h want=%h", rr, OKAY); end
    axi_read(A_C, rd, rr);
    total++; if (rd !== 32'h24) begin bad++; $display("FAIL ro_write_c got=%h want=24", rd); end
  endtask

  task automatic test_reset_mid();
    logic [41:0] obs; logic [31:0] rd; logic [1:0] rr;
    axi_write(A_CTRL, 32'h1, 4'h1, rr);
    arvalid = 1; araddr = A_A; rready = 0;
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    total++; if ({rvalid, rdata} !== {1'b1, 32'h100}) begin bad++; $display("FAIL mid_pending got=%h want=%h", {rvalid, rdata}, {1'b1, 32'h100}); end
    #1 nreset = 0;
    #1;
    obs = {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, irq};
    total++; if (obs !== RST_VEC) begin bad++; $display("FAIL mid_reset_outputs got=%h want=%h", obs, RST_VEC); end
    @(posedge clk);
    @(posedge clk); #1;
    nreset = 1;
    @(posedge clk); #1;
    axi_read(A_CTRL, rd, rr);
    total++; if (rd !== 32'h4) begin bad++; $display("FAIL mid_ctrl got=%h want=4", rd); end
    axi_read(A_COUNT, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_count got=%h want=0", rd); end
    axi_read(A_C, rd, rr);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_c got=%h want=0", rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 nreset = 1;
    test_reset();
    test_basic_add();
    test_carry();
    test_wstrb();
    test_irq();
    test_skew(1'b1, 32'h11);
    test_skew(1'b0, 32'h22);
    test_busy_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
